// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU memory bus: MMIO offsets, address
// decode predicates and load-lane alignment.
package mem_bus_pkg;

  localparam logic [3:0] MMIO_OFF_TOHOST = 4'h0;
  localparam logic [3:0] MMIO_OFF_CYCLE  = 4'h4;

  // Which source a registered read result comes from.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_MMIO = 2'd2
  } rd_src_e;

  function automatic logic in_mem(input logic [31:0] addr, input int unsigned mem_words);
    return {1'b0, addr} < ({1'b0, 32'(mem_words)} << 2);
  endfunction

  function automatic logic in_mmio(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

  function automatic logic in_range(input logic [31:0] addr, input int unsigned mem_words,
                                    input logic [31:0] base);
    return in_mem(addr, mem_words) || in_mmio(addr, base);
  endfunction

  // Loads are right-aligned so sub-word loads always take the low bits.
  function automatic logic [31:0] lane_shift(input logic [31:0] word, input logic [1:0] off);
    return word >> {off, 3'b000};
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mem_bank_dp.sv
// Word-wide storage with one byte-enabled read/write port and one
// read-only port; both reads are registered and read-first.
module mem_bank_dp #(
  parameter int unsigned WORDS     = 16384,
  parameter int unsigned AW        = $clog2(WORDS),
  parameter string       INIT_FILE = ""
) (
  input  logic          clk,
  input  logic [3:0]    i_a_be,
  input  logic          i_a_re,
  input  logic [AW-1:0] i_a_addr,
  input  logic [31:0]   i_a_wdata,
  output logic [31:0]   o_a_rdata,
  input  logic          i_b_re,
  input  logic [AW-1:0] i_b_addr,
  output logic [31:0]   o_b_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_a_q;
  logic [31:0] r_b_q;

  // NOTE: the array has no reset; downstream source-select flops make
  // the visible outputs zero after reset, so stale read registers are harmless.
  // NOTE: non-blocking reads and writes in one block give read-first
  // behaviour: a same-edge read sees the word as it was before the write.
  always_ff @(posedge clk) begin
    if (i_a_re) r_a_q <= r_mem[i_a_addr];
    if (i_b_re) r_b_q <= r_mem[i_b_addr];
    for (int i = 0; i < 4; i++) begin
      if (i_a_be[i]) r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
    end
  end

  assign o_a_rdata = r_a_q;
  assign o_b_rdata = r_b_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the single-cycle CPU: shared instruction/data
// array plus a small MMIO window (tohost halt register, cycle counter).
module cpu_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  input  logic        data_read,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_in,
  output logic [31:0] instr_out,
  output logic [31:0] data_out,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic        w_i_mem, w_i_mmio, w_i_ok;
  logic        w_d_mem, w_d_mmio, w_d_ok;
  logic        w_d_wr, w_tohost_we;
  logic [3:0]  w_bank_be;
  logic [31:0] w_bank_a_q, w_bank_b_q;
  logic [31:0] w_i_mmio_val, w_d_mmio_val;
  logic [31:0] w_d_word;

  logic [31:0] r_cycle;
  logic        r_halt;
  logic [31:0] r_halt_code;
  logic        r_err;
  rd_src_e     r_i_src, r_d_src;
  logic [31:0] r_i_mmio, r_d_mmio;
  logic [1:0]  r_d_off;

  assign w_i_mem  = in_mem(instr_addr, MEM_WORDS);
  assign w_i_mmio = in_mmio(instr_addr, MMIO_BASE);
  assign w_i_ok   = in_range(instr_addr, MEM_WORDS, MMIO_BASE);
  assign w_d_mem  = in_mem(data_addr, MEM_WORDS);
  assign w_d_mmio = in_mmio(data_addr, MMIO_BASE);
  assign w_d_ok   = in_range(data_addr, MEM_WORDS, MMIO_BASE);
  assign w_d_wr   = |data_write;

  assign w_tohost_we = w_d_wr && w_d_mmio && (data_addr[3:2] == MMIO_OFF_TOHOST[3:2]);
  // The array has no reset, so a store landing on a reset edge must be gated here.
  assign w_bank_be   = (w_d_mem && !rst) ? data_write : 4'b0000;

  mem_bank_dp #(
    .WORDS     (MEM_WORDS),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_bank (
    .clk       (clk),
    .i_a_be    (w_bank_be),
    .i_a_re    (data_read && w_d_mem),
    .i_a_addr  (data_addr[AW+1:2]),
    .i_a_wdata (data_in),
    .o_a_rdata (w_bank_a_q),
    .i_b_re    (instr_read && w_i_mem),
    .i_b_addr  (instr_addr[AW+1:2]),
    .o_b_rdata (w_bank_b_q)
  );

  always_comb begin
    w_i_mmio_val = 32'h0;
    w_d_mmio_val = 32'h0;
    if (instr_addr[3:2] == MMIO_OFF_TOHOST[3:2])     w_i_mmio_val = r_halt_code;
    else if (instr_addr[3:2] == MMIO_OFF_CYCLE[3:2]) w_i_mmio_val = r_cycle;
    if (data_addr[3:2] == MMIO_OFF_TOHOST[3:2])      w_d_mmio_val = r_halt_code;
    else if (data_addr[3:2] == MMIO_OFF_CYCLE[3:2])  w_d_mmio_val = r_cycle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle     <= 32'h0;
      r_halt      <= 1'b0;
      r_halt_code <= 32'h0;
      r_err       <= 1'b0;
      r_i_src     <= SRC_ZERO;
      r_d_src     <= SRC_ZERO;
      r_i_mmio    <= 32'h0;
      r_d_mmio    <= 32'h0;
      r_d_off     <= 2'b00;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (instr_read) begin
        r_i_src  <= w_i_mem ? SRC_MEM : (w_i_mmio ? SRC_MMIO : SRC_ZERO);
        r_i_mmio <= w_i_mmio_val;
      end
      if (data_read) begin
        r_d_src  <= w_d_mem ? SRC_MEM : (w_d_mmio ? SRC_MMIO : SRC_ZERO);
        r_d_mmio <= w_d_mmio_val;
        r_d_off  <= data_addr[1:0];
      end
      if (w_tohost_we && !r_halt) begin
        r_halt      <= 1'b1;
        r_halt_code <= data_in & lane_mask(data_write);
      end
      if ((instr_read && !w_i_ok) || ((data_read || w_d_wr) && !w_d_ok)) r_err <= 1'b1;
    end
  end

  always_comb begin
    instr_out = 32'h0;
    w_d_word  = 32'h0;
    case (r_i_src)
      SRC_MEM:  instr_out = w_bank_b_q;
      SRC_MMIO: instr_out = r_i_mmio;
      default:  instr_out = 32'h0;
    endcase
    case (r_d_src)
      SRC_MEM:  w_d_word = w_bank_a_q;
      SRC_MMIO: w_d_word = r_d_mmio;
      default:  w_d_word = 32'h0;
    endcase
  end

  assign data_out  = lane_shift(w_d_word, r_d_off);
  assign halt      = r_halt;
  assign halt_code = r_halt_code;
  assign err       = r_err;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: fetch, aligned loads, byte stores,
// read-first, MMIO halt/cycle, out-of-range handling and mid-run reset.
module tb_cpu_mem_responder;

  localparam logic [31:0] MMIO = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_addr;
  logic        data_read;
  logic [31:0] data_addr;
  logic [3:0]  data_write;
  logic [31:0] data_in;
  logic [31:0] instr_out;
  logic [31:0] data_out;
  logic        halt;
  logic [31:0] halt_code;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_mem_responder #(
    .MEM_WORDS (16384),
    .MMIO_BASE (MMIO),
    .INIT_FILE ("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_read (instr_read),
    .instr_addr (instr_addr),
    .data_read  (data_read),
    .data_addr  (data_addr),
    .data_write (data_write),
    .data_in    (data_in),
    .instr_out  (instr_out),
    .data_out   (data_out),
    .halt       (halt),
    .halt_code  (halt_code),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_read = 1'b0;
    data_read  = 1'b0;
    data_write = 4'b0000;
  endtask

  initial begin
    rst        = 1'b1;
    instr_addr = 32'h0;
    data_addr  = 32'h0;
    data_in    = 32'h0;
    idle_inputs();
    #12;
    check("reset_instr_out", instr_out, 32'h0);
    check("reset_data_out",  data_out,  32'h0);
    check("reset_halt",      {31'h0, halt}, 32'h0);
    check("reset_halt_code", halt_code, 32'h0);
    check("reset_err",       {31'h0, err},  32'h0);
    rst = 1'b0;

    // Place the first instruction word, then fetch it.
    data_addr = 32'h0; data_in = 32'h0050_0093; data_write = 4'hF;
    step();
    idle_inputs();
    instr_read = 1'b1; instr_addr = 32'h0;
    step();
    check("fetch_word0", instr_out, 32'h0050_0093);
    instr_read = 1'b0; instr_addr = 32'h100;
    step();
    check("fetch_hold", instr_out, 32'h0050_0093);

    // Word store then lane-aligned loads.
    data_addr = 32'h100; data_in = 32'hDEAD_BEEF; data_write = 4'hF;
    step();
    idle_inputs();
    data_read = 1'b1; data_addr = 32'h103;
    step();
    check("load_b3", data_out, 32'h0000_00DE);
    data_addr = 32'h102;
    step();
    check("load_h2", data_out, 32'h0000_DEAD);

    // Byte store with a same-edge load: load sees pre-write data.
    data_addr = 32'h100; data_in = 32'h7777_7777; data_write = 4'b0100;
    step();
    check("read_first", data_out, 32'hDEAD_BEEF);
    data_write = 4'b0000;
    step();
    check("byte_store", data_out, 32'hDE77_BEEF);
    data_read = 1'b0;
    instr_read = 1'b1; instr_addr = 32'h100;
    step();
    check("fetch_0x100", instr_out, 32'hDE77_BEEF);
    idle_inputs();

    // TOHOST: first write wins.
    data_addr = MMIO; data_in = 32'h2A; data_write = 4'hF;
    step();
    check("halt_set",  {31'h0, halt}, 32'h1);
    check("halt_code", halt_code, 32'h2A);
    data_in = 32'h5;
    step();
    check("halt_code_sticky", halt_code, 32'h2A);
    idle_inputs();
    data_read = 1'b1; data_addr = MMIO;
    step();
    check("tohost_read", data_out, 32'h2A);
    data_addr = MMIO + 32'h8;
    step();
    check("mmio_res_read", data_out, 32'h0);
    check("err_clear", {31'h0, err}, 32'h0);

    // Out-of-range load and store (0x10000 would alias word 0 if not decoded).
    data_addr = 32'h0001_0000;
    step();
    check("oor_load_data", data_out, 32'h0);
    check("oor_load_err",  {31'h0, err}, 32'h1);
    idle_inputs();
    data_in = 32'hCAFE_F00D; data_write = 4'hF;
    step();
    idle_inputs();
    data_read = 1'b1; data_addr = 32'h0;
    step();
    check("oor_store_dropped", data_out, 32'h0050_0093);
    idle_inputs();

    // Mid-run reset, with a store presented on the reset edge.
    data_addr = 32'h100; data_in = 32'h1234_5678; data_write = 4'hF;
    rst = 1'b1;
    #1;
    check("mid_rst_instr_out", instr_out, 32'h0);
    check("mid_rst_data_out",  data_out,  32'h0);
    check("mid_rst_halt",      {31'h0, halt}, 32'h0);
    check("mid_rst_halt_code", halt_code, 32'h0);
    check("mid_rst_err",       {31'h0, err},  32'h0);
    step();
    idle_inputs();
    rst = 1'b0;

    // Edge 1 after reset: confirm the store on the reset edge was dropped.
    data_read = 1'b1; data_addr = 32'h100;
    step();
    check("rst_edge_store_dropped", data_out, 32'hDE77_BEEF);
    data_read = 1'b0;
    repeat (8) step();
    // Edge 10: counter value before this edge's increment is 9.
    data_read = 1'b1; data_addr = MMIO + 32'h4;
    step();
    check("cycle_read", data_out, 32'd9);
    idle_inputs();

    // TOHOST honours byte enables.
    data_addr = MMIO; data_in = 32'h1122_3344; data_write = 4'b0011;
    step();
    idle_inputs();
    check("masked_halt",      {31'h0, halt}, 32'h1);
    check("masked_halt_code", halt_code, 32'h0000_3344);

    // Out-of-range fetch.
    instr_read = 1'b1; instr_addr = 32'h0002_0000;
    step();
    check("oor_fetch_data", instr_out, 32'h0);
    check("oor_fetch_err",  {31'h0, err}, 32'h1);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
